// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment receive path.
// The segment encodings are active-low with bit6=g .. bit0=a, matching the
// encoder on the transmit side. The package also holds the BCD blank code,
// the error cause codes, the scan FSM states and a multi-hot helper.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK  = 4'hF;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
    localparam logic [1:0] ERR_SELECT  = 2'b10;

    typedef enum logic {
        TRACK,
        HOLD
    } scan_state_e;

    // True when more than one bit of the select vector is set.
    function automatic logic isMultiHot(input logic [7:0] sel);
        return (sel & (sel - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the multiplexed display bus and the monitor's read-back outputs.
//   master : drives HexSeg, DigitSel, ClearErr; observes the decoded results
//   slave  : the scan decoder itself
// Signals:
//   HexSeg     active-low segment lines (bit6=g .. bit0=a)
//   DigitSel   one-hot digit enable, all-zero = blanking interval
//   ClearErr   synchronous clear of Error/ErrCode
//   Digits     BCD per digit, digit k at [4k+3:4k]
//   DigitValid digit k holds a numeral
//   Update     one-cycle commit pulse, UpdateIdx = digit written
//   Decimal    value of last commit, 8'hFF if it was a blank
//   Error      sticky error flag, ErrCode = cause of the first error
// ---------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              HexSeg;
    logic [NUM_DIGITS-1:0]   DigitSel;
    logic                    ClearErr;
    logic [4*NUM_DIGITS-1:0] Digits;
    logic [NUM_DIGITS-1:0]   DigitValid;
    logic                    Update;
    logic [2:0]              UpdateIdx;
    logic [7:0]              Decimal;
    logic                    Error;
    logic [1:0]              ErrCode;

    modport master (
        output HexSeg, DigitSel, ClearErr,
        input  Digits, DigitValid, Update, UpdateIdx, Decimal, Error, ErrCode
    );

    modport slave (
        input  HexSeg, DigitSel, ClearErr,
        output Digits, DigitValid, Update, UpdateIdx, Decimal, Error, ErrCode
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the 7-segment encoder.
//   seg_i   : active-low segment pattern
//   legal_o : pattern is one of the numerals 0-9
//   blank_o : pattern is all segments off
//   value_o : decoded numeral, BCD_BLANK when not a numeral
// ---------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        legal_o = 1'b1;
        blank_o = 1'b0;
        value_o = BCD_BLANK;
        case (seg_i)
            SEG_0:     value_o = 4'd0;
            SEG_1:     value_o = 4'd1;
            SEG_2:     value_o = 4'd2;
            SEG_3:     value_o = 4'd3;
            SEG_4:     value_o = 4'd4;
            SEG_5:     value_o = 4'd5;
            SEG_6:     value_o = 4'd6;
            SEG_7:     value_o = 4'd7;
            SEG_8:     value_o = 4'd8;
            SEG_9:     value_o = 4'd9;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed active-low 7-segment display bus and reconstructs
// the BCD value shown on each digit. A (pattern, select) pair must be seen
// STABLE_CYCLES consecutive samples before it is committed; a pattern held
// indefinitely commits exactly once.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_decoder_if slave modport (inputs and read-back outputs)
// ---------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_decoder_if.slave   bus
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [6:0]              segQ;
    logic [NUM_DIGITS-1:0]   selQ;
    logic [7:0]              cntQ,       cntD;
    scan_state_e             stateQ,     stateD;
    logic [4*NUM_DIGITS-1:0] digitsQ,    digitsD;
    logic [NUM_DIGITS-1:0]   validQ,     validD;
    logic                    updateQ,    updateD;
    logic [2:0]              updateIdxQ, updateIdxD;
    logic [7:0]              decimalQ,   decimalD;
    logic                    errorQ,     errorD;
    logic [1:0]              errCodeQ,   errCodeD;

    logic                    change;
    logic                    commit;
    logic                    decLegal;
    logic                    decBlank;
    logic [3:0]              decValue;
    logic                    newErr;
    logic [1:0]              newCode;

    seg7_pattern_decode u_decode (
        .seg_i   (segQ),
        .legal_o (decLegal),
        .blank_o (decBlank),
        .value_o (decValue)
    );

    // The comparison is made between the incoming value and the last
    // sample, so cntQ counts identical samples held in the input register.
    assign change = (bus.HexSeg != segQ) || (bus.DigitSel != selQ);

    always_comb begin
        cntD = cntQ;
        if (change) begin
            cntD = 8'd1;
        end else if (cntQ != STABLE_CNT) begin
            cntD = cntQ + 8'd1;
        end
    end

    // Commit fires on the TRACK->HOLD step. If the input changes in that
    // same cycle we stay in TRACK so the new value gets its own commit.
    always_comb begin
        stateD = stateQ;
        commit = 1'b0;
        case (stateQ)
            TRACK: begin
                if (cntQ == STABLE_CNT) begin
                    commit = 1'b1;
                    stateD = change ? TRACK : HOLD;
                end
            end
            HOLD: begin
                if (change) begin
                    stateD = TRACK;
                end
            end
            default: stateD = TRACK;
        endcase
    end

    always_comb begin
        digitsD    = digitsQ;
        validD     = validQ;
        updateD    = 1'b0;
        updateIdxD = updateIdxQ;
        decimalD   = decimalQ;
        newErr     = 1'b0;
        newCode    = ERR_NONE;
        if (commit && (selQ != '0)) begin
            if (isMultiHot(8'(selQ))) begin
                newErr  = 1'b1;
                newCode = ERR_SELECT;
            end else if (decLegal || decBlank) begin
                updateD  = 1'b1;
                decimalD = decBlank ? 8'hFF : {4'h0, decValue};
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (selQ[k]) begin
                        digitsD[4*k +: 4] = decBlank ? BCD_BLANK : decValue;
                        validD[k]         = decLegal;
                        updateIdxD        = 3'(k);
                    end
                end
            end else begin
                newErr  = 1'b1;
                newCode = ERR_PATTERN;
            end
        end
    end

    // A new error in the same cycle as ClearErr wins over the clear.
    always_comb begin
        errorD   = errorQ;
        errCodeD = errCodeQ;
        if (bus.ClearErr) begin
            errorD   = 1'b0;
            errCodeD = ERR_NONE;
        end
        if (newErr && (!errorQ || bus.ClearErr)) begin
            errorD   = 1'b1;
            errCodeD = newCode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segQ       <= SEG_BLANK;
            selQ       <= '0;
            cntQ       <= 8'd0;
            stateQ     <= TRACK;
            digitsQ    <= {NUM_DIGITS{BCD_BLANK}};
            validQ     <= '0;
            updateQ    <= 1'b0;
            updateIdxQ <= 3'd0;
            decimalQ   <= 8'hFF;
            errorQ     <= 1'b0;
            errCodeQ   <= ERR_NONE;
        end else begin
            segQ       <= bus.HexSeg;
            selQ       <= bus.DigitSel;
            cntQ       <= cntD;
            stateQ     <= stateD;
            digitsQ    <= digitsD;
            validQ     <= validD;
            updateQ    <= updateD;
            updateIdxQ <= updateIdxD;
            decimalQ   <= decimalD;
            errorQ     <= errorD;
            errCodeQ   <= errCodeD;
        end
    end

    assign bus.Digits     = digitsQ;
    assign bus.DigitValid = validQ;
    assign bus.Update     = updateQ;
    assign bus.UpdateIdx  = updateIdxQ;
    assign bus.Decimal    = decimalQ;
    assign bus.Error      = errorQ;
    assign bus.ErrCode    = errCodeQ;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Expected commits are queued when stimulus is driven and compared when the
// decoder raises Update; status outputs are checked at fixed points.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int NUM_DIGITS = 4;
    localparam int STABLE     = 4;

    typedef struct {
        int         idx;
        logic [3:0] digit;
        logic       valid;
        logic [7:0] dec;
        int         edgeNo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         edgeCount;
    int         checkCount;
    int         passCount;
    exp_t       sbQ[$];
    logic [6:0] segTable [10];
    logic [6:0] decSeg;
    logic       decLegal;
    logic       decBlank;
    logic [3:0] decValue;

    seg7_scan_decoder_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seg7_pattern_decode u_refDecode (
        .seg_i   (decSeg),
        .legal_o (decLegal),
        .blank_o (decBlank),
        .value_o (decValue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        edgeCount = 0;
        forever begin
            @(posedge clk);
            edgeCount++;
        end
    end

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", tag, actual, expected, edgeCount);
        end
    endtask

    // Queues the commit a stable one-hot numeral or blank should produce.
    task automatic expectCommit(input logic [3:0] sel, input logic [6:0] seg, input int edgeNo);
        exp_t e;
        if (!$onehot(sel)) return;
        e.idx = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) e.idx = k;
        end
        e.edgeNo = edgeNo;
        if (seg == 7'h7F) begin
            e.digit = 4'hF;
            e.valid = 1'b0;
            e.dec   = 8'hFF;
            sbQ.push_back(e);
            return;
        end
        for (int v = 0; v < 10; v++) begin
            if (segTable[v] == seg) begin
                e.digit = 4'(v);
                e.valid = 1'b1;
                e.dec   = 8'(v);
                sbQ.push_back(e);
            end
        end
    endtask

    // Called on a falling edge; holds the pair for the given number of cycles.
    task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        int startEdge;
        bus.DigitSel = sel;
        bus.HexSeg   = seg;
        startEdge    = edgeCount + 1;
        if (cycles >= STABLE) expectCommit(sel, seg, startEdge + STABLE);
        repeat (cycles) @(negedge clk);
    endtask

    // Scoreboard: every Update must match the oldest queued commit.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.Update) begin
            if (sbQ.size() == 0) begin
                checkOutput("spuriousUpdate", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("updEdge",  32'(edgeCount), 32'(e.edgeNo));
                checkOutput("updIdx",   32'(bus.UpdateIdx), 32'(e.idx));
                checkOutput("updDec",   32'(bus.Decimal), 32'(e.dec));
                checkOutput("updDigit", 32'(bus.Digits[4*e.idx +: 4]), 32'(e.digit));
                checkOutput("updValid", 32'(bus.DigitValid[e.idx]), 32'(e.valid));
            end
        end else if (sbQ.size() > 0 && sbQ[0].edgeNo < edgeCount) begin
            checkOutput("missedUpdate", 32'(edgeCount), 32'(sbQ[0].edgeNo));
            void'(sbQ.pop_front());
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Digits"},  32'(bus.Digits), 32'h0000FFFF);
        checkOutput({tag, "Valid"},   32'(bus.DigitValid), 32'h0);
        checkOutput({tag, "Update"},  32'(bus.Update), 32'h0);
        checkOutput({tag, "Idx"},     32'(bus.UpdateIdx), 32'h0);
        checkOutput({tag, "Decimal"}, 32'(bus.Decimal), 32'hFF);
        checkOutput({tag, "Error"},   32'(bus.Error), 32'h0);
        checkOutput({tag, "ErrCode"}, 32'(bus.ErrCode), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        segTable   = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        rst_n        = 1'b0;
        bus.HexSeg   = 7'h7F;
        bus.DigitSel = '0;
        bus.ClearErr = 1'b0;
        decSeg       = 7'h7F;

        // Pattern decoder table against independent constants.
        for (int v = 0; v < 10; v++) begin
            decSeg = segTable[v];
            #1;
            checkOutput($sformatf("decode%0d", v), {29'd0, decLegal, decBlank, 1'b0}, {29'd0, 3'b100});
            checkOutput($sformatf("decodeVal%0d", v), 32'(decValue), 32'(v));
        end
        decSeg = 7'h7F;
        #1;
        checkOutput("decodeBlank", {29'd0, decLegal, decBlank, 1'b0}, {29'd0, 3'b010});
        decSeg = 7'b0101010;
        #1;
        checkOutput("decodeIllegal", {28'd0, decLegal, decBlank, decValue[1:0]}, {28'd0, 4'b0011});

        repeat (2) @(negedge clk);
        checkResetValues("rst");
        rst_n = 1'b1;

        // Static digit: 2 on digit 0.
        applyStimulus(4'b0001, 7'b0100100, 6);
        checkOutput("staticDigit", 32'(bus.Digits[3:0]), 32'h2);
        checkOutput("staticValid", 32'(bus.DigitValid), 32'b0001);
        checkOutput("staticDec",   32'(bus.Decimal), 32'h02);

        // Glitch: 3 for three cycles is rejected, then 4 commits.
        applyStimulus(4'b0010, 7'b0110000, 3);
        applyStimulus(4'b0010, 7'b0011001, 4);
        repeat (2) @(negedge clk);
        checkOutput("glitchDigit", 32'(bus.Digits[7:4]), 32'h4);

        // Full scan showing 9,0,7,5 with a blanking cycle between digits.
        applyStimulus(4'b0001, 7'h10, 5);
        applyStimulus(4'b0000, 7'h7F, 1);
        applyStimulus(4'b0010, 7'h40, 5);
        applyStimulus(4'b0000, 7'h7F, 1);
        applyStimulus(4'b0100, 7'h78, 5);
        applyStimulus(4'b0000, 7'h7F, 1);
        applyStimulus(4'b1000, 7'h12, 5);
        applyStimulus(4'b0000, 7'h7F, 1);
        checkOutput("scanDigits", 32'(bus.Digits), 32'h5709);
        checkOutput("scanValid",  32'(bus.DigitValid), 32'hF);

        // Illegal pattern, then multi-hot while the first error is held.
        applyStimulus(4'b0100, 7'b0101010, 5);
        checkOutput("patErr",      32'(bus.Error), 32'h1);
        checkOutput("patCode",     32'(bus.ErrCode), 32'h1);
        checkOutput("patDigit",    32'(bus.Digits[11:8]), 32'h7);
        applyStimulus(4'b0011, 7'h79, 5);
        checkOutput("firstWinsErr",  32'(bus.Error), 32'h1);
        checkOutput("firstWinsCode", 32'(bus.ErrCode), 32'h1);
        checkOutput("selDigits",     32'(bus.Digits), 32'h5709);
        bus.ClearErr = 1'b1;
        @(negedge clk);
        bus.ClearErr = 1'b0;
        checkOutput("clearErr",  32'(bus.Error), 32'h0);
        checkOutput("clearCode", 32'(bus.ErrCode), 32'h0);

        // Multi-hot from a clear state, then a clear that collides with a new error.
        applyStimulus(4'b1100, 7'h12, 5);
        checkOutput("selErr",  32'(bus.Error), 32'h1);
        checkOutput("selCode", 32'(bus.ErrCode), 32'h2);
        bus.DigitSel = 4'b0001;
        bus.HexSeg   = 7'b0101010;
        repeat (4) @(negedge clk);
        bus.ClearErr = 1'b1;
        @(negedge clk);
        bus.ClearErr = 1'b0;
        checkOutput("collideErr",  32'(bus.Error), 32'h1);
        checkOutput("collideCode", 32'(bus.ErrCode), 32'h1);

        // Blank commit on digit 0.
        applyStimulus(4'b0001, 7'h7F, 5);
        checkOutput("blankValid", 32'(bus.DigitValid), 32'hE);
        checkOutput("blankDigit", 32'(bus.Digits[3:0]), 32'hF);
        checkOutput("blankDec",   32'(bus.Decimal), 32'hFF);

        // Reset in the middle of counting 8 on digit 3.
        applyStimulus(4'b1000, 7'h00, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midRst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1000, 7'h00, 6);
        checkOutput("postRstDigit", 32'(bus.Digits[15:12]), 32'h8);
        checkOutput("postRstValid", 32'(bus.DigitValid), 32'h8);

        repeat (3) @(negedge clk);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
